// File: rtl/hs_cdc_afifo_rd_ctrl_if.sv
// rtl/hs_cdc_afifo_rd_ctrl_if.sv - read-side controller bus bundle (pointer, RAM port, output stream)
//
// Signals:
//   wptr_sync  synchronized binary write pointer (ADDR_WIDTH+1)
//   ram_ren    RAM read enable
//   ram_raddr  RAM read address
//   ram_rdata  RAM read data, one cycle after ram_ren
//   rd_valid   output word available
//   rd_ready   consumer accepts rd_data
//   rd_data    oldest buffered word
//   rptr_gray  gray read pointer toward the write domain
//   rd_avail   words in RAM not yet issued
//   ptr_err    sticky illegal-pointer flag
// Modports: master = controller side, slave = surrounding FIFO / consumer side.

interface hs_cdc_afifo_rd_ctrl_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH:0]   wptr_sync;
    logic                  ram_ren;
    logic [ADDR_WIDTH-1:0] ram_raddr;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic                  rd_valid;
    logic                  rd_ready;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [ADDR_WIDTH:0]   rptr_gray;
    logic [ADDR_WIDTH:0]   rd_avail;
    logic                  ptr_err;

    modport master (
        input  wptr_sync, ram_rdata, rd_ready,
        output ram_ren, ram_raddr, rd_valid, rd_data, rptr_gray, rd_avail, ptr_err
    );

    modport slave (
        output wptr_sync, ram_rdata, rd_ready,
        input  ram_ren, ram_raddr, rd_valid, rd_data, rptr_gray, rd_avail, ptr_err
    );
endinterface

// File: rtl/hs_cdc_afifo_rd_ctrl.sv
// rtl/hs_cdc_afifo_rd_ctrl.sv - async FIFO read-side controller with 2-entry FWFT output buffer
//
// Ports:
//   clk      read-domain clock
//   aresetn  asynchronous active-low reset
//   bus      hs_cdc_afifo_rd_ctrl_if.master: write pointer in, RAM read port,
//            valid/ready output stream, gray read pointer, occupancy, error flag

module hs_cdc_afifo_rd_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input logic                     clk,
    input logic                     aresetn,
    hs_cdc_afifo_rd_ctrl_if.master  bus
);
    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [PW-1:0]         rptr;
    logic [PW-1:0]         rptr_gray_q;
    logic [PW-1:0]         rptr_inc;
    logic [PW-1:0]         avail_raw;
    logic                  inflight;
    logic                  ptr_err_q;
    logic                  pop;
    logic                  push;
    logic                  ren;
    logic [1:0]            cnt;
    logic [1:0]            cnt_next;
    logic [2:0]            occ;
    logic [DATA_WIDTH-1:0] obuf0;
    logic [DATA_WIDTH-1:0] obuf1;

    assign avail_raw = bus.wptr_sync - rptr;
    assign pop       = (cnt != 2'd0) && bus.rd_ready;
    assign push      = inflight;

    // Buffer slots already spoken for next cycle: what is held, plus the word
    // landing from the RAM, minus the word leaving this cycle.
    assign occ = {1'b0, cnt} + {2'b00, inflight} - {2'b00, pop};

    // Gating with aresetn keeps the RAM quiet while reset is held even though
    // wptr_sync may already be non-zero.
    assign ren      = aresetn && (avail_raw != '0) && !ptr_err_q && (occ < 3'd2);
    assign rptr_inc = rptr + PW'(1);
    assign cnt_next = cnt + {1'b0, push} - {1'b0, pop};

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            rptr        <= '0;
            rptr_gray_q <= '0;
            inflight    <= 1'b0;
            ptr_err_q   <= 1'b0;
        end else begin
            inflight <= ren;
            if (ren) begin
                rptr        <= rptr_inc;
                rptr_gray_q <= rptr_inc ^ (rptr_inc >> 1);
            end
            // More than DEPTH unread words cannot happen with sane pointers.
            if (avail_raw > DEPTH) begin
                ptr_err_q <= 1'b1;
            end
        end
    end

    // obuf0 is always the head; obuf1 only holds data when cnt == 2.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            cnt   <= 2'd0;
            obuf0 <= '0;
            obuf1 <= '0;
        end else begin
            cnt <= cnt_next;
            case ({push, pop})
                2'b11: begin
                    if (cnt == 2'd2) begin
                        obuf0 <= obuf1;
                        obuf1 <= bus.ram_rdata;
                    end else begin
                        obuf0 <= bus.ram_rdata;
                    end
                end
                2'b10: begin
                    if (cnt == 2'd0) begin
                        obuf0 <= bus.ram_rdata;
                    end else begin
                        obuf1 <= bus.ram_rdata;
                    end
                end
                2'b01: obuf0 <= obuf1;
                default: ;
            endcase
        end
    end

    assign bus.ram_ren   = ren;
    assign bus.ram_raddr = rptr[ADDR_WIDTH-1:0];
    assign bus.rd_valid  = (cnt != 2'd0);
    assign bus.rd_data   = obuf0;
    assign bus.rptr_gray = rptr_gray_q;
    assign bus.rd_avail  = aresetn ? avail_raw : '0;
    assign bus.ptr_err   = ptr_err_q;

endmodule

// File: tb/tb_hs_cdc_afifo_rd_ctrl.sv
// tb/tb_hs_cdc_afifo_rd_ctrl.sv - directed self-checking bench for hs_cdc_afifo_rd_ctrl

module tb_hs_cdc_afifo_rd_ctrl;
    logic clk;
    logic aresetn;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   ren_cnt = 0;

    logic [31:0] mem [16];
    logic [31:0] got [$];
    int          pop_cyc [$];
    logic [3:0]  raddr_log [$];
    logic [4:0]  gray_log [$];
    logic [4:0]  last_gray = '0;

    hs_cdc_afifo_rd_ctrl_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) bus ();

    hs_cdc_afifo_rd_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) dut (
        .clk     (clk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // 1-cycle-latency RAM model
    always @(posedge clk) begin
        if (bus.ram_ren) bus.ram_rdata <= mem[bus.ram_raddr];
    end

    always @(negedge clk) begin
        if (bus.rd_valid && bus.rd_ready) begin
            got.push_back(bus.rd_data);
            pop_cyc.push_back(cyc);
        end
        if (bus.ram_ren) begin
            ren_cnt = ren_cnt + 1;
            raddr_log.push_back(bus.ram_raddr);
        end
        if (bus.rptr_gray != last_gray) begin
            gray_log.push_back(bus.rptr_gray);
            last_gray = bus.rptr_gray;
        end
    end

    function automatic logic [31:0] pat(int k);
        return 32'hC0DE_0000 + k;
    endfunction

    function automatic logic [4:0] gray5(int n);
        logic [4:0] b;
        b = n[4:0];
        return b ^ (b >> 1);
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        bus.wptr_sync = 5'd5;
        bus.rd_ready = 1'b0;
        bus.ram_rdata = '0;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            #2;
            total++; if (bus.ram_ren !== 1'b0) begin bad++; $display("FAIL reset_ram_ren got=%0b exp=0", bus.ram_ren); end
        end
        total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid got=%0b exp=0", bus.rd_valid); end
        total++; if (bus.rd_data !== 32'h0) begin bad++; $display("FAIL reset_rd_data got=%h exp=0", bus.rd_data); end
        total++; if (bus.rptr_gray !== 5'h0) begin bad++; $display("FAIL reset_rptr_gray got=%h exp=0", bus.rptr_gray); end
        total++; if (bus.rd_avail !== 5'h0) begin bad++; $display("FAIL reset_rd_avail got=%0d exp=0", bus.rd_avail); end
        total++; if (bus.ptr_err !== 1'b0) begin bad++; $display("FAIL reset_ptr_err got=%0b exp=0", bus.ptr_err); end
        total++; if (bus.ram_raddr !== 4'h0) begin bad++; $display("FAIL reset_ram_raddr got=%0d exp=0", bus.ram_raddr); end
        next_cycle();
        bus.wptr_sync = 5'd0;
        aresetn = 1'b1;
        next_cycle();
    endtask

    task automatic test_single_word();
        next_cycle();
        mem[0] = 32'hA5;
        bus.wptr_sync = 5'd1;
        #2;
        total++; if (bus.ram_ren !== 1'b1) begin bad++; $display("FAIL single_ren_t got=%0b exp=1", bus.ram_ren); end
        total++; if (bus.ram_raddr !== 4'd0) begin bad++; $display("FAIL single_raddr got=%0d exp=0", bus.ram_raddr); end
        total++; if (bus.rd_avail !== 5'd1) begin bad++; $display("FAIL single_avail got=%0d exp=1", bus.rd_avail); end
        next_cycle(); #2;
        total++; if (bus.ram_ren !== 1'b0) begin bad++; $display("FAIL single_ren_t1 got=%0b exp=0", bus.ram_ren); end
        total++; if (bus.rptr_gray !== 5'd1) begin bad++; $display("FAIL single_gray_t1 got=%0d exp=1", bus.rptr_gray); end
        total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL single_valid_t1 got=%0b exp=0", bus.rd_valid); end
        next_cycle(); #2;
        total++; if (bus.rd_valid !== 1'b1) begin bad++; $display("FAIL single_valid_t2 got=%0b exp=1", bus.rd_valid); end
        total++; if (bus.rd_data !== 32'hA5) begin bad++; $display("FAIL single_data_t2 got=%h exp=a5", bus.rd_data); end
        next_cycle();
        bus.rd_ready = 1'b1;
        #2;
        total++; if (bus.rd_data !== 32'hA5) begin bad++; $display("FAIL single_data_hold got=%h exp=a5", bus.rd_data); end
        next_cycle();
        bus.rd_ready = 1'b0;
        #2;
        total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL single_valid_after_pop got=%0b exp=0", bus.rd_valid); end
    endtask

    task automatic test_streaming_wrap();
        logic [4:0] prev;
        got.delete(); pop_cyc.delete(); raddr_log.delete(); gray_log.delete();
        bus.rd_ready = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            next_cycle();
            mem[k % 16] = pat(k);
            bus.wptr_sync = 5'((k + 1) % 32);
        end
        for (int i = 0; i < 60 && got.size() < 40; i++) next_cycle();
        next_cycle();
        total++; if (got.size() != 40) begin bad++; $display("FAIL stream_count got=%0d exp=40", got.size()); end
        if (got.size() == 40) begin
            for (int i = 0; i < 40; i++) begin
                total++; if (got[i] !== pat(i + 1)) begin bad++; $display("FAIL stream_data[%0d] got=%h exp=%h", i, got[i], pat(i + 1)); end
            end
            total++; if (pop_cyc[39] - pop_cyc[0] != 39) begin bad++; $display("FAIL stream_rate span=%0d exp=39", pop_cyc[39] - pop_cyc[0]); end
        end
        total++; if (raddr_log.size() != 40) begin bad++; $display("FAIL stream_ren_count got=%0d exp=40", raddr_log.size()); end
        if (raddr_log.size() == 40) begin
            for (int i = 0; i < 40; i++) begin
                total++; if (raddr_log[i] !== 4'((i + 1) % 16)) begin bad++; $display("FAIL stream_raddr[%0d] got=%0d exp=%0d", i, raddr_log[i], (i + 1) % 16); end
            end
        end
        total++; if (gray_log.size() != 40) begin bad++; $display("FAIL stream_gray_count got=%0d exp=40", gray_log.size()); end
        if (gray_log.size() == 40) begin
            prev = 5'b00001;
            for (int i = 0; i < 40; i++) begin
                total++; if (gray_log[i] !== gray5(i + 2) || $countones(gray_log[i] ^ prev) != 1) begin
                    bad++; $display("FAIL stream_gray[%0d] got=%b exp=%b", i, gray_log[i], gray5(i + 2));
                end
                prev = gray_log[i];
            end
        end
    endtask

    task automatic test_back_pressure();
        int ren0;
        bus.rd_ready = 1'b0;
        got.delete();
        next_cycle();
        ren0 = ren_cnt;
        for (int k = 41; k <= 56; k++) mem[k % 16] = pat(k);
        bus.wptr_sync = 5'd25;
        #2;
        total++; if (bus.rd_avail !== 5'd16) begin bad++; $display("FAIL bp_full_avail got=%0d exp=16", bus.rd_avail); end
        total++; if (bus.ram_ren !== 1'b1) begin bad++; $display("FAIL bp_first_ren got=%0b exp=1", bus.ram_ren); end
        for (int i = 0; i < 6; i++) next_cycle();
        #2;
        total++; if (ren_cnt - ren0 != 2) begin bad++; $display("FAIL bp_issued got=%0d exp=2", ren_cnt - ren0); end
        total++; if (bus.rd_avail !== 5'd14) begin bad++; $display("FAIL bp_avail got=%0d exp=14", bus.rd_avail); end
        total++; if (bus.ram_ren !== 1'b0) begin bad++; $display("FAIL bp_ren_stopped got=%0b exp=0", bus.ram_ren); end
        total++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== pat(41)) begin bad++; $display("FAIL bp_head got=%0b/%h exp=1/%h", bus.rd_valid, bus.rd_data, pat(41)); end
        total++; if (bus.ptr_err !== 1'b0) begin bad++; $display("FAIL bp_ptr_err got=%0b exp=0", bus.ptr_err); end
        next_cycle();
        bus.rd_ready = 1'b1;
        for (int i = 0; i < 60 && got.size() < 16; i++) next_cycle();
        for (int i = 0; i < 4; i++) next_cycle();
        #2;
        total++; if (got.size() != 16) begin bad++; $display("FAIL bp_drain_count got=%0d exp=16", got.size()); end
        if (got.size() == 16) begin
            for (int i = 0; i < 16; i++) begin
                total++; if (got[i] !== pat(41 + i)) begin bad++; $display("FAIL bp_drain[%0d] got=%h exp=%h", i, got[i], pat(41 + i)); end
            end
        end
        total++; if (bus.rd_avail !== 5'd0) begin bad++; $display("FAIL bp_avail_end got=%0d exp=0", bus.rd_avail); end
    endtask

    task automatic test_simul_push_pop();
        got.delete();
        bus.rd_ready = 1'b1;
        next_cycle(); mem[9]  = pat(57); bus.wptr_sync = 5'd26;
        next_cycle(); mem[10] = pat(58); bus.wptr_sync = 5'd27;
        next_cycle(); mem[11] = pat(59); bus.wptr_sync = 5'd28;
        #2;
        total++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== pat(57)) begin bad++; $display("FAIL spp_head0 got=%0b/%h exp=1/%h", bus.rd_valid, bus.rd_data, pat(57)); end
        total++; if (bus.ram_ren !== 1'b1) begin bad++; $display("FAIL spp_issue_with_pop got=%0b exp=1", bus.ram_ren); end
        next_cycle(); #2;
        total++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== pat(58)) begin bad++; $display("FAIL spp_head1 got=%0b/%h exp=1/%h", bus.rd_valid, bus.rd_data, pat(58)); end
        next_cycle(); #2;
        total++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== pat(59)) begin bad++; $display("FAIL spp_head2 got=%0b/%h exp=1/%h", bus.rd_valid, bus.rd_data, pat(59)); end
        next_cycle(); #2;
        total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL spp_empty got=%0b exp=0", bus.rd_valid); end
        total++; if (got.size() != 3) begin bad++; $display("FAIL spp_count got=%0d exp=3", got.size()); end
    endtask

    task automatic test_error_and_reset();
        int ren0;
        bus.rd_ready = 1'b0;
        next_cycle();
        mem[12] = pat(60); mem[13] = pat(61);
        bus.wptr_sync = 5'd30;
        for (int i = 0; i < 4; i++) next_cycle();
        bus.wptr_sync = 5'd15;
        #2;
        total++; if (bus.rd_avail !== 5'd17) begin bad++; $display("FAIL err_avail got=%0d exp=17", bus.rd_avail); end
        total++; if (bus.ptr_err !== 1'b0) begin bad++; $display("FAIL err_not_yet got=%0b exp=0", bus.ptr_err); end
        next_cycle(); #2;
        total++; if (bus.ptr_err !== 1'b1) begin bad++; $display("FAIL err_set got=%0b exp=1", bus.ptr_err); end
        ren0 = ren_cnt;
        got.delete();
        bus.rd_ready = 1'b1;
        for (int i = 0; i < 8; i++) next_cycle();
        #2;
        total++; if (ren_cnt != ren0) begin bad++; $display("FAIL err_no_issue got=%0d exp=0", ren_cnt - ren0); end
        total++; if (got.size() != 2) begin bad++; $display("FAIL err_drain_count got=%0d exp=2", got.size()); end
        if (got.size() == 2) begin
            total++; if (got[0] !== pat(60) || got[1] !== pat(61)) begin bad++; $display("FAIL err_drain_data got=%h,%h exp=%h,%h", got[0], got[1], pat(60), pat(61)); end
        end
        total++; if (bus.ptr_err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%0b exp=1", bus.ptr_err); end

        next_cycle();
        aresetn = 1'b0;
        bus.wptr_sync = 5'd0;
        #2;
        total++; if (bus.ptr_err !== 1'b0) begin bad++; $display("FAIL rst_ptr_err got=%0b exp=0", bus.ptr_err); end
        total++; if (bus.rptr_gray !== 5'd0 || bus.ram_raddr !== 4'd0) begin bad++; $display("FAIL rst_rptr got=%0d/%0d exp=0/0", bus.rptr_gray, bus.ram_raddr); end
        next_cycle();
        aresetn = 1'b1;

        got.delete();
        bus.rd_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            mem[k] = pat(100 + k);
            bus.wptr_sync = 5'(k + 1);
        end
        next_cycle();
        aresetn = 1'b0;
        #2;
        total++; if (bus.rd_valid !== 1'b0 || bus.ram_ren !== 1'b0) begin bad++; $display("FAIL mid_rst_outputs got=%0b/%0b exp=0/0", bus.rd_valid, bus.ram_ren); end
        bus.wptr_sync = 5'd0;
        next_cycle();
        aresetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            next_cycle(); #2;
            total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_stale_word got=%0b exp=0", bus.rd_valid); end
        end
        total++; if (bus.rptr_gray !== 5'd0 || bus.ram_raddr !== 4'd0 || bus.ptr_err !== 1'b0) begin
            bad++; $display("FAIL mid_rst_state got=%0d/%0d/%0b exp=0/0/0", bus.rptr_gray, bus.ram_raddr, bus.ptr_err);
        end
        total++; if (got.size() != 1) begin bad++; $display("FAIL mid_rst_pops got=%0d exp=1", got.size()); end
        else begin
            total++; if (got[0] !== pat(100)) begin bad++; $display("FAIL mid_rst_first got=%h exp=%h", got[0], pat(100)); end
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        test_reset();
        test_single_word();
        test_streaming_wrap();
        test_back_pressure();
        test_simul_push_pop();
        test_error_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/hs_cdc_afifo_rd_ctrl.md
# hs_cdc_afifo_rd_ctrl

Read-side controller of the asynchronous FIFO. It sits in the read clock domain, directly downstream of the gray-encoded multi-bit synchronizer that carries the write pointer. It consumes the synchronized binary write pointer, computes occupancy, and issues reads to a 1-cycle-latency dual-port RAM. It presents first-word-fall-through data on a valid/ready interface through a 2-entry output buffer, and produces the gray read pointer that the write-side synchronizer consumes.

## Interface
- ADDR_WIDTH, 4: RAM address width; FIFO depth = 2^ADDR_WIDTH; legal range 2-16.
- DATA_WIDTH, 32: data word width; legal range 1-1024.

- clk  input  1  read-domain clock; all logic on rising edge.
- aresetn  input  1  asynchronous, active-low reset; deassertion is assumed synchronized externally.
- wptr_sync  input  ADDR_WIDTH+1  binary write pointer, already synchronized and gray-decoded; treated as registered in clk.
- ram_ren  output  1  RAM read enable (combinational).
- ram_raddr  output  ADDR_WIDTH  RAM read address = rptr[ADDR_WIDTH-1:0].
- ram_rdata  input  DATA_WIDTH  RAM read data, valid the cycle after ram_ren.
- rd_valid  output  1  output buffer holds at least one word.
- rd_ready  input  1  consumer accepts rd_data.
- rd_data  output  DATA_WIDTH  oldest buffered word.
- rptr_gray  output  ADDR_WIDTH+1  registered gray-coded read pointer, fed to the write domain.
- rd_avail  output  ADDR_WIDTH+1  words in RAM not yet issued = wptr_sync - rptr (mod 2^(ADDR_WIDTH+1)).
- ptr_err  output  1  sticky flag: pointer relation illegal.

## Operation
- State: rptr (binary, ADDR_WIDTH+1), rptr_gray register, inflight (0/1), 2-entry output buffer with count cnt (0..2), ptr_err.
- pop = rd_valid && rd_ready; rd_valid = (cnt != 0); rd_data = buffer head.
- ram_ren = (rd_avail != 0) && !ptr_err && (cnt + inflight - pop < 2).
- On ram_ren: rptr <= rptr + 1, wrapping modulo 2^(ADDR_WIDTH+1). rptr_gray <= gray(rptr + 1) = (n >> 1) ^ n. inflight <= 1. Otherwise inflight <= 0.
- When inflight == 1, ram_rdata is written to the buffer tail in the same cycle. A simultaneous push and pop keeps cnt unchanged and preserves order.
- The read pointer advances at issue, not at pop. The buffer owns issued words, so the write side may reuse those slots.
- ptr_err is set when rd_avail > 2^ADDR_WIDTH and stays set until reset. While set, no reads are issued, and buffered words still drain.
- Empty condition: rd_avail == 0 stops issue. Words in flight and in the buffer still drain.
- Full FIFO (rd_avail == 2^ADDR_WIDTH) is legal.
- Wrap-around: the MSB of rptr toggles every 2^ADDR_WIDTH reads. ram_raddr ignores the MSB.
- Reset values: rptr = 0, rptr_gray = 0, inflight = 0, cnt = 0, rd_valid = 0, rd_data = 0, ptr_err = 0, ram_ren = 0.
- Reset mid-operation clears all buffered and in-flight data immediately. A RAM word returning after reset is ignored.

## Timing
- First-word latency: wptr_sync changes 0 -> 1 in cycle t. Then ram_ren = 1 in cycle t, the word lands at the end of t+1, and rd_valid = 1 in cycle t+2.
- Throughput: 1 word/cycle sustained while rd_ready = 1 and rd_avail > 0.
- Back-pressure: with rd_ready held low, at most 2 words are buffered. Issue stops when cnt + inflight == 2.
- rptr_gray changes in the cycle after ram_ren. Only one bit changes per update.
- rd_data and rd_valid are stable while rd_valid && !rd_ready.

## Test plan
- Reset: hold aresetn low with wptr_sync = 5 -> all outputs 0, and ram_ren stays 0 during reset.
- Single word: ADDR_WIDTH = 4, wptr_sync 0 -> 1 at cycle 10, RAM returns 0xA5 -> ram_ren in cycle 10 only, rd_valid and rd_data = 0xA5 at cycle 12, rptr_gray = 1 at cycle 11.
- Streaming and wrap: ramp wptr_sync to 40 with rd_ready = 1 -> 40 words popped in order, one per cycle after the first. ram_raddr wraps 15 -> 0, and rptr_gray steps through gray(0..40) one bit at a time.
- Back-pressure: wptr_sync = 16 (full), rd_ready = 0 -> exactly 2 reads issued and rd_avail = 14. Releasing rd_ready drains all 16 in order, with no loss or duplication.
- Simultaneous push and pop: cnt = 1, inflight = 1, rd_ready = 1 -> cnt stays 1 and the issue continues in the same cycle.
- Error and reset: jump wptr_sync to rptr + 17 -> ptr_err = 1 next cycle and no further ram_ren. Assert aresetn mid-stream -> ptr_err = 0, rd_valid = 0, rptr = 0.
